register_file_bypass: RTL and testbench

REGISTER_FILE_BYPASS -- requirements
Module: register_file_bypass

---
 rtl/register_file_bypass_pkg.sv | 16 +
 rtl/register_file_bypass_write_decoder.sv | 19 +
 rtl/register_file_bypass.sv | 75 +++++++
 tb/tb_register_file_bypass.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/register_file_bypass_pkg.sv
// Shared constants and types for the 16 x 16-bit register file with
// same-cycle write-to-read forwarding.
package register_file_bypass_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;

  typedef logic [DATA_W-1:0]    reg_word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  wordline_t;

  localparam reg_idx_t  ZERO_REG  = '0;
  localparam reg_word_t ZERO_WORD = '0;

endpackage

// File: rtl/register_file_bypass_write_decoder.sv
// 4-to-16 write decoder: one-hot wordline for the selected register,
// all zeros when the enable is low.
module WriteDecoder_4_16
  import register_file_bypass_pkg::*;
(
  input  logic      en_i,
  input  reg_idx_t  idx_i,
  output wordline_t wordline_o
);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wordline_o = '0;
    if (en_i) begin
      wordline_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_bypass.sv
// Register file with two combinational read ports, one write port, a
// hardwired-zero R0 and optional write-before-read forwarding.
module register_file_bypass
  import register_file_bypass_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_idx_t  SrcReg1,
  input  reg_idx_t  SrcReg2,
  input  reg_idx_t  DstReg,
  input  logic      WriteReg,
  input  reg_word_t DstData,
  output reg_word_t SrcData1,
  output reg_word_t SrcData2
);

  wordline_t wordline;
  logic      write_en;
  logic      fwd_en;
  reg_word_t regs_q [NUM_REGS];
  reg_word_t regs_d [NUM_REGS];

  // Writes to R0 never reach the decoder, so its row only ever holds zero.
  assign write_en = WriteReg && (DstReg != ZERO_REG);
  assign fwd_en   = BYPASS && write_en && !rst;

  WriteDecoder_4_16 u_write_decoder (
    .en_i       (write_en),
    .idx_i      (DstReg),
    .wordline_o (wordline)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wordline[i]) begin
        regs_d[i] = DstData;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all rows update together at the edge.
  // NOTE: the storage is flops, not an SRAM macro, so clearing every row on reset is cheap and required.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: ZERO_WORD};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Priority, lowest to highest: stored value, forwarded write data, forced zero.
  always_comb begin
    SrcData1 = regs_q[SrcReg1];
    if (fwd_en && (SrcReg1 == DstReg)) begin
      SrcData1 = DstData;
    end
    if (rst || (SrcReg1 == ZERO_REG)) begin
      SrcData1 = ZERO_WORD;
    end
  end

  always_comb begin
    SrcData2 = regs_q[SrcReg2];
    if (fwd_en && (SrcReg2 == DstReg)) begin
      SrcData2 = DstData;
    end
    if (rst || (SrcReg2 == ZERO_REG)) begin
      SrcData2 = ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_register_file_bypass.sv
// Scoreboard bench: drives a forwarding and a non-forwarding instance with
// the same stimulus and checks both against an array-based model.
module tb_register_file_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, dst;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rd1_b, rd2_b, rd1_n, rd2_n;

  always #5 clk = ~clk;

  register_file_bypass #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst),
    .WriteReg(we), .DstData(wdata), .SrcData1(rd1_b), .SrcData2(rd2_b)
  );

  register_file_bypass #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst),
    .WriteReg(we), .DstData(wdata), .SrcData1(rd1_n), .SrcData2(rd2_n)
  );

  typedef struct {
    string       name;
    logic [15:0] e1b, e2b, e1n, e2n;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [16];
  int          total = 0;
  int          bad   = 0;
  bit          stim_done = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What a read port must show this cycle, from the architectural rules.
  function automatic logic [15:0] model_read(input bit byp, input logic [3:0] idx);
    if (rst || idx == 4'd0) return 16'h0000;
    if (byp && we && dst != 4'd0 && dst == idx) return wdata;
    return mem[idx];
  endfunction

  task automatic cycle(input string name, input bit r, input logic [3:0] s1, input logic [3:0] s2,
                       input bit w, input logic [3:0] d, input logic [15:0] data);
    exp_t e;
    rst = r; src1 = s1; src2 = s2; we = w; dst = d; wdata = data;
    e.name = name;
    e.e1b = model_read(1'b1, s1);
    e.e2b = model_read(1'b1, s2);
    e.e1n = model_read(1'b0, s1);
    e.e2n = model_read(1'b0, s2);
    sb.push_back(e);
    if (r) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    end else if (w && d != 4'd0) begin
      mem[d] = data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 16; i += 2) begin
      cycle(name, 1'b0, 4'(i), 4'(i + 1), 1'b0, 4'd0, 16'h0000);
    end
  endtask

  // Monitor: outputs are combinational, so every stimulus cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "/byp1"}, rd1_b, e.e1b);
        check({e.name, "/byp2"}, rd2_b, e.e2b);
        check({e.name, "/nobyp1"}, rd1_n, e.e1n);
        check({e.name, "/nobyp2"}, rd2_n, e.e2n);
      end
    end
  end

  initial begin
    logic [3:0]  rd, r1, r2;
    logic [15:0] rv;
    bit          rr, rw;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst = 1'b1; src1 = '0; src2 = '0; dst = '0; we = 1'b0; wdata = '0;
    @(posedge clk);
    #1;

    cycle("reset_write_lost", 1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 16'hA5A5);
    sweep("post_reset_sweep");

    cycle("write_r5", 1'b0, 4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF);
    cycle("read_r5", 1'b0, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0000);
    sweep("after_r5_sweep");

    cycle("fwd_r7", 1'b0, 4'd7, 4'd6, 1'b1, 4'd7, 16'h1234);
    cycle("read_r7", 1'b0, 4'd7, 4'd7, 1'b0, 4'd0, 16'h0000);

    cycle("write_r0", 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF);
    cycle("read_r0", 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000);

    cycle("no_we_r9", 1'b0, 4'd9, 4'd9, 1'b0, 4'd9, 16'h5555);
    cycle("read_r9", 1'b0, 4'd9, 4'd9, 1'b0, 4'd0, 16'h0000);
    cycle("no_we_xdata", 1'b0, 4'd5, 4'd9, 1'b0, 4'd5, 16'hxxxx);
    cycle("read_after_x", 1'b0, 4'd5, 4'd7, 1'b0, 4'd0, 16'h0000);

    cycle("write_r3", 1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 16'h1111);
    cycle("rst_vs_write_r3", 1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 16'hA5A5);
    cycle("read_r3_after_rst", 1'b0, 4'd3, 4'd5, 1'b0, 4'd0, 16'h0000);

    cycle("b2b_write_r4", 1'b0, 4'd4, 4'd2, 1'b1, 4'd4, 16'h4444);
    cycle("b2b_write_r2", 1'b0, 4'd4, 4'd2, 1'b1, 4'd2, 16'h2222);
    cycle("b2b_rst", 1'b1, 4'd4, 4'd2, 1'b1, 4'd6, 16'h6666);
    cycle("b2b_resume_r4", 1'b0, 4'd4, 4'd2, 1'b1, 4'd4, 16'h4545);
    sweep("b2b_sweep");

    for (int n = 0; n < 1200; n++) begin
      rr = ($urandom_range(0, 39) == 0);
      rw = ($urandom_range(0, 3) != 0);
      rd = 4'($urandom_range(0, 15));
      rv = 16'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 4'($urandom_range(0, 15));
      cycle("random", rr, r1, r2, rw, rd, rw ? rv : 16'hxxxx);
    end
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end

endmodule
